// File: rtl/alub_operand_buffer_if.sv
// rtl/alub_operand_buffer_if.sv - request/response bundle for the ALU B-operand buffer
//
// Groups the request side (flush, in_valid/in_ready, sel, data_b, imm and,
// with ALUB_ZEXT_EN defined, imm_zext) and the result side (out_valid/out_ready,
// out_data, occupancy). The master modport drives requests and consumes results;
// the slave modport is the buffer itself.
interface alub_operand_buffer_if #(
    parameter int WIDTH     = 32,
    parameter int IMM_WIDTH = 16
);
    logic                 flush;
    logic                 in_valid;
    logic                 in_ready;
    logic [1:0]           sel;
    logic [WIDTH-1:0]     data_b;
    logic [IMM_WIDTH-1:0] imm;
`ifdef ALUB_ZEXT_EN
    logic                 imm_zext;
`endif
    logic                 out_valid;
    logic                 out_ready;
    logic [WIDTH-1:0]     out_data;
    logic [1:0]           occupancy;

`ifdef ALUB_ZEXT_EN
    modport master (
        output flush, in_valid, sel, data_b, imm, imm_zext, out_ready,
        input  in_ready, out_valid, out_data, occupancy
    );
    modport slave (
        input  flush, in_valid, sel, data_b, imm, imm_zext, out_ready,
        output in_ready, out_valid, out_data, occupancy
    );
`else
    modport master (
        output flush, in_valid, sel, data_b, imm, out_ready,
        input  in_ready, out_valid, out_data, occupancy
    );
    modport slave (
        input  flush, in_valid, sel, data_b, imm, out_ready,
        output in_ready, out_valid, out_data, occupancy
    );
`endif
endinterface

// File: rtl/alub_operand_buffer.sv
// rtl/alub_operand_buffer.sv - ALU B-operand selector with a registered two-entry FIFO
//
// Selects the B operand (data_b, CONST_VAL, ext(imm), ext(imm) << SHIFT), and
// queues the computed value in a two-entry FIFO towards the ALU.
// Optional feature macro: ALUB_ZEXT_EN adds imm_zext, which makes selects 2/3
// zero-extend the immediate instead of sign-extending it.
//
// Ports:
//   clk    - rising-edge clock
//   rst_n  - synchronous active-low reset
//   bus    - alub_operand_buffer_if.slave (request, result and occupancy signals)
module alub_operand_buffer #(
    parameter int WIDTH     = 32,
    parameter int IMM_WIDTH = 16,
    parameter int CONST_VAL = 4,
    parameter int SHIFT     = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    alub_operand_buffer_if.slave  bus
);
    logic [WIDTH-1:0] r_mem0;
    logic [WIDTH-1:0] r_mem1;
    logic             r_head;
    logic             r_tail;
    logic [1:0]       r_count;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_out_data;

    logic [WIDTH-1:0] w_ext;
    logic [WIDTH-1:0] w_operand;
    logic             w_in_ready;
    logic             w_push;
    logic             w_pop;
    logic [WIDTH-1:0] w_mem0_n;
    logic [WIDTH-1:0] w_mem1_n;
    logic             w_head_n;
    logic             w_tail_n;
    logic [1:0]       w_count_n;
    logic [WIDTH-1:0] w_head_data_n;

`ifdef ALUB_ZEXT_EN
    assign w_ext = bus.imm_zext ? WIDTH'(bus.imm) : WIDTH'($signed(bus.imm));
`else
    assign w_ext = WIDTH'($signed(bus.imm));
`endif

    always_comb begin
        w_operand = bus.data_b;
        case (bus.sel)
            2'd0:    w_operand = bus.data_b;
            2'd1:    w_operand = WIDTH'(CONST_VAL);
            2'd2:    w_operand = w_ext;
            default: w_operand = w_ext << SHIFT;
        endcase
    end

    // Ready depends only on the count register, never on out_ready, so a full
    // buffer does not accept even when the head is being consumed.
    assign w_in_ready = rst_n && (r_count != 2'd2);
    assign w_push     = bus.in_valid && w_in_ready;
    assign w_pop      = r_out_valid && bus.out_ready;

    always_comb begin
        w_mem0_n = r_mem0;
        w_mem1_n = r_mem1;
        if (w_push) begin
            if (r_tail) w_mem1_n = w_operand;
            else        w_mem0_n = w_operand;
        end
        w_head_n      = r_head ^ w_pop;
        w_tail_n      = r_tail ^ w_push;
        w_count_n     = r_count + 2'(w_push) - 2'(w_pop);
        w_head_data_n = w_head_n ? w_mem1_n : w_mem0_n;
    end

    // out_data is a register tracking the next-cycle head so the ALU sees a
    // flop output; it holds its last value while the buffer is empty.
    always_ff @(posedge clk) begin
        if (!rst_n || bus.flush) begin
            r_mem0      <= '0;
            r_mem1      <= '0;
            r_head      <= 1'b0;
            r_tail      <= 1'b0;
            r_count     <= 2'd0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
        end else begin
            r_mem0      <= w_mem0_n;
            r_mem1      <= w_mem1_n;
            r_head      <= w_head_n;
            r_tail      <= w_tail_n;
            r_count     <= w_count_n;
            r_out_valid <= (w_count_n != 2'd0);
            if (w_count_n != 2'd0) r_out_data <= w_head_data_n;
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
    assign bus.occupancy = r_count;
endmodule

// File: tb/tb_alub_operand_buffer.sv
// tb/tb_alub_operand_buffer.sv - directed self-checking bench for alub_operand_buffer
module tb_alub_operand_buffer;
    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    alub_operand_buffer_if #(.WIDTH(32), .IMM_WIDTH(16)) bus ();

    alub_operand_buffer #(
        .WIDTH(32), .IMM_WIDTH(16), .CONST_VAL(4), .SHIFT(2)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change at negedge; one call advances through exactly one posedge.
    task automatic step();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        bus.flush     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.sel       = 2'd0;
        bus.data_b    = 32'h0;
        bus.imm       = 16'h0;
`ifdef ALUB_ZEXT_EN
        bus.imm_zext  = 1'b0;
`endif
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle_inputs();
        step();
        step();
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%0b exp=0", bus.out_valid); end
        total++; if (bus.occupancy !== 2'd0) begin bad++; $display("FAIL reset_occupancy got=%0d exp=0", bus.occupancy); end
        total++; if (bus.out_data !== 32'h0) begin bad++; $display("FAIL reset_out_data got=%h exp=0", bus.out_data); end
        total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready got=%0b exp=0", bus.in_ready); end
        rst_n = 1'b1;
        step();
        total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL reset_release_in_ready got=%0b exp=1", bus.in_ready); end
    endtask

    task automatic test_source_sweep();
        logic [31:0] exp_v [4];
        exp_v[0] = 32'hDEADBEEF;
        exp_v[1] = 32'h00000004;
        exp_v[2] = 32'hFFFF8001;
        exp_v[3] = 32'hFFFE0004;
        bus.out_ready = 1'b1;
        bus.data_b    = 32'hDEADBEEF;
        bus.imm       = 16'h8001;
        for (int i = 0; i < 4; i++) begin
            bus.in_valid = 1'b1;
            bus.sel      = 2'(i);
            step();
            total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL sweep_valid sel=%0d got=%0b exp=1", i, bus.out_valid); end
            total++; if (bus.out_data !== exp_v[i]) begin bad++; $display("FAIL sweep_data sel=%0d got=%h exp=%h", i, bus.out_data, exp_v[i]); end
            total++; if (bus.occupancy !== 2'd1) begin bad++; $display("FAIL sweep_occ sel=%0d got=%0d exp=1", i, bus.occupancy); end
        end
        bus.in_valid = 1'b0;
        step();
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL sweep_drained got=%0b exp=0", bus.out_valid); end
    endtask

    task automatic test_backpressure();
        bus.out_ready = 1'b0;
        bus.sel       = 2'd0;
        bus.in_valid  = 1'b1;
        bus.data_b    = 32'h1111_0001;
        step();
        total++; if (bus.occupancy !== 2'd1) begin bad++; $display("FAIL bp_occ1 got=%0d exp=1", bus.occupancy); end
        total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL bp_ready1 got=%0b exp=1", bus.in_ready); end
        bus.data_b = 32'h2222_0002;
        step();
        total++; if (bus.occupancy !== 2'd2) begin bad++; $display("FAIL bp_occ2 got=%0d exp=2", bus.occupancy); end
        total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL bp_ready2 got=%0b exp=0", bus.in_ready); end
        total++; if (bus.out_data !== 32'h1111_0001) begin bad++; $display("FAIL bp_head got=%h exp=11110001", bus.out_data); end
        bus.data_b = 32'h3333_0003;
        step();
        total++; if (bus.occupancy !== 2'd2) begin bad++; $display("FAIL bp_third_rejected got=%0d exp=2", bus.occupancy); end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        total++; if (bus.out_data !== 32'h1111_0001) begin bad++; $display("FAIL bp_drain1 got=%h exp=11110001", bus.out_data); end
        step();
        total++; if (bus.out_data !== 32'h2222_0002) begin bad++; $display("FAIL bp_drain2 got=%h exp=22220002", bus.out_data); end
        total++; if (bus.occupancy !== 2'd1) begin bad++; $display("FAIL bp_drain_occ got=%0d exp=1", bus.occupancy); end
        step();
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL bp_empty got=%0b exp=0", bus.out_valid); end
    endtask

    task automatic test_push_pop();
        bus.out_ready = 1'b0;
        bus.sel       = 2'd0;
        bus.in_valid  = 1'b1;
        bus.data_b    = 32'hAAAA_5555;
        step();
        total++; if (bus.occupancy !== 2'd1) begin bad++; $display("FAIL pp_occ_before got=%0d exp=1", bus.occupancy); end
        bus.data_b    = 32'h0BAD_F00D;
        bus.out_ready = 1'b1;
        step();
        total++; if (bus.occupancy !== 2'd1) begin bad++; $display("FAIL pp_occ got=%0d exp=1", bus.occupancy); end
        total++; if (bus.out_data !== 32'h0BAD_F00D) begin bad++; $display("FAIL pp_head got=%h exp=0badf00d", bus.out_data); end
        bus.in_valid = 1'b0;
        step();
        total++; if (bus.occupancy !== 2'd0) begin bad++; $display("FAIL pp_drain got=%0d exp=0", bus.occupancy); end
    endtask

    task automatic test_flush();
        bus.out_ready = 1'b0;
        bus.sel       = 2'd0;
        bus.in_valid  = 1'b1;
        bus.data_b    = 32'h0000_00F1;
        step();
        bus.data_b = 32'h0000_00F2;
        step();
        total++; if (bus.occupancy !== 2'd2) begin bad++; $display("FAIL fl_occ_before got=%0d exp=2", bus.occupancy); end
        bus.flush  = 1'b1;
        bus.data_b = 32'h0000_00F3;
        step();
        bus.flush    = 1'b0;
        bus.in_valid = 1'b0;
        total++; if (bus.occupancy !== 2'd0) begin bad++; $display("FAIL fl_occ got=%0d exp=0", bus.occupancy); end
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL fl_valid got=%0b exp=0", bus.out_valid); end
        step();
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL fl_no_ghost got=%0b exp=0", bus.out_valid); end
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        bus.data_b    = 32'h0000_00F4;
        step();
        bus.in_valid = 1'b0;
        total++; if (bus.out_data !== 32'h0000_00F4) begin bad++; $display("FAIL fl_after got=%h exp=000000f4", bus.out_data); end
        step();
    endtask

    task automatic test_midreset();
        bus.out_ready = 1'b0;
        bus.sel       = 2'd0;
        bus.in_valid  = 1'b1;
        bus.data_b    = 32'h5A5A_0001;
        step();
        bus.data_b = 32'h5A5A_0002;
        step();
        bus.in_valid = 1'b0;
        total++; if (bus.occupancy !== 2'd2) begin bad++; $display("FAIL mr_occ_before got=%0d exp=2", bus.occupancy); end
        rst_n = 1'b0;
        step();
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL mr_valid got=%0b exp=0", bus.out_valid); end
        total++; if (bus.out_data !== 32'h0) begin bad++; $display("FAIL mr_data got=%h exp=0", bus.out_data); end
        total++; if (bus.occupancy !== 2'd0) begin bad++; $display("FAIL mr_occ got=%0d exp=0", bus.occupancy); end
        total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL mr_ready_low got=%0b exp=0", bus.in_ready); end
        rst_n = 1'b1;
        step();
        total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL mr_ready_after got=%0b exp=1", bus.in_ready); end
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL mr_valid_after got=%0b exp=0", bus.out_valid); end
    endtask

`ifdef ALUB_ZEXT_EN
    task automatic test_zext();
        logic [31:0] exp_v [4];
        logic [1:0]  sel_v [4];
        logic        zx_v  [4];
        sel_v[0] = 2'd2; zx_v[0] = 1'b1; exp_v[0] = 32'h00008001;
        sel_v[1] = 2'd3; zx_v[1] = 1'b1; exp_v[1] = 32'h00020004;
        sel_v[2] = 2'd2; zx_v[2] = 1'b0; exp_v[2] = 32'hFFFF8001;
        sel_v[3] = 2'd3; zx_v[3] = 1'b0; exp_v[3] = 32'hFFFE0004;
        bus.out_ready = 1'b1;
        bus.imm       = 16'h8001;
        bus.data_b    = 32'hCAFE_0000;
        for (int i = 0; i < 4; i++) begin
            bus.in_valid = 1'b1;
            bus.sel      = sel_v[i];
            bus.imm_zext = zx_v[i];
            step();
            total++; if (bus.out_data !== exp_v[i]) begin bad++; $display("FAIL zext_case%0d got=%h exp=%h", i, bus.out_data, exp_v[i]); end
        end
        bus.sel      = 2'd0;
        bus.imm_zext = 1'b1;
        step();
        total++; if (bus.out_data !== 32'hCAFE_0000) begin bad++; $display("FAIL zext_sel0 got=%h exp=cafe0000", bus.out_data); end
        bus.in_valid = 1'b0;
        bus.imm_zext = 1'b0;
        step();
    endtask
`endif

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_source_sweep();
        test_backpressure();
        test_push_pop();
        test_flush();
        test_midreset();
`ifdef ALUB_ZEXT_EN
        test_zext();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
